// File: rtl/wilton_pkg.sv
// Shared types and helpers for the Wilton switch box: direction codes, per-output
// select encoding and configuration-chain states.
package wilton_pkg;

   typedef enum logic [1:0] {DIR_N, DIR_E, DIR_S, DIR_W} dir_e;

   typedef logic [1:0] sel_t;
   localparam sel_t SEL_LEFT     = 2'b00;
   localparam sel_t SEL_STRAIGHT = 2'b01;
   localparam sel_t SEL_RIGHT    = 2'b10;
   localparam sel_t SEL_OFF      = 2'b11;

   typedef enum logic [1:0] {CFG_EMPTY, CFG_LOADING, CFG_FULL} cfg_state_e;

   // Source side feeding output side o; SEL_OFF aliases to the self side and must be
   // masked by the caller.
   function automatic dir_e src_dir(input dir_e o, input sel_t sel);
      logic [1:0] d;
      d = 2'(o) + sel + 2'd1;
      return dir_e'(d);
   endfunction

endpackage

// File: rtl/wilton_cfg_chain.sv
// Serial configuration chain: shadow shift register with bit counter, load-state FSM,
// commit/error handshake and the active routing register.
module wilton_cfg_chain
   import wilton_pkg::*;
#(
   parameter int unsigned CFG_BITS = 64
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                cfg_in,
   input  logic                cfg_shift,
   input  logic                cfg_commit,
   input  logic                cfg_clear,
   output logic                cfg_out,
   output logic                cfg_done,
   output logic                cfg_err,
   output logic                cfg_full,
   output logic [CFG_BITS-1:0] active
);

   localparam int unsigned CNT_W = $clog2(CFG_BITS + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_BITS - 1);

   logic [CFG_BITS-1:0] shadow_q, shadow_d;
   logic [CFG_BITS-1:0] active_q, active_d;
   logic [CNT_W-1:0]    count_q, count_d;
   cfg_state_e          state_q, state_d;
   logic                err_q, err_d;
   logic                done_q, done_d;

   always_comb begin
      shadow_d = shadow_q;
      active_d = active_q;
      count_d  = count_q;
      state_d  = state_q;
      err_d    = err_q;
      done_d   = 1'b0;
      if (cfg_clear) begin
         count_d = '0;
         state_d = CFG_EMPTY;
         err_d   = 1'b0;
      end else if (cfg_shift && cfg_commit) begin
         err_d = 1'b1;
      end else if (cfg_shift) begin
         shadow_d = {shadow_q[CFG_BITS-2:0], cfg_in};
         case (state_q)
            CFG_EMPTY, CFG_LOADING: begin
               count_d = count_q + CNT_W'(1);
               state_d = (count_q == CNT_LAST) ? CFG_FULL : CFG_LOADING;
            end
            CFG_FULL: err_d = 1'b1;  // overflow: data still shifts, count saturates
            default: state_d = CFG_EMPTY;
         endcase
      end else if (cfg_commit) begin
         if (state_q == CFG_FULL) begin
            active_d = shadow_q;
            done_d   = 1'b1;
            count_d  = '0;
            state_d  = CFG_EMPTY;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= '0;
         active_q <= '1;
         count_q  <= '0;
         state_q  <= CFG_EMPTY;
         err_q    <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
         count_q  <= count_d;
         state_q  <= state_d;
         err_q    <= err_d;
         done_q   <= done_d;
      end
   end

   assign cfg_out  = shadow_q[CFG_BITS-1];
   assign cfg_done = done_q;
   assign cfg_err  = err_q;
   assign cfg_full = (state_q == CFG_FULL);
   assign active   = active_q;

endmodule

// File: rtl/wilton_sb_cfg.sv
// Wilton switch box with per-output-lane source selects, driven by an atomically
// committed serial configuration chain.
module wilton_sb_cfg
   import wilton_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned REG_OUT = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] in_n,
   input  logic [WIDTH-1:0] in_e,
   input  logic [WIDTH-1:0] in_s,
   input  logic [WIDTH-1:0] in_w,
   output logic [WIDTH-1:0] out_n,
   output logic [WIDTH-1:0] out_e,
   output logic [WIDTH-1:0] out_s,
   output logic [WIDTH-1:0] out_w,
   input  logic             cfg_in,
   input  logic             cfg_shift,
   input  logic             cfg_commit,
   input  logic             cfg_clear,
   output logic             cfg_out,
   output logic             cfg_done,
   output logic             cfg_err,
   output logic             cfg_full
);

   localparam int unsigned CFG_BITS = WIDTH * 8;

   logic [CFG_BITS-1:0] active;
   logic [WIDTH-1:0]    din   [4];
   logic [WIDTH-1:0]    route [4];
   logic [WIDTH-1:0]    dout  [4];

   wilton_cfg_chain #(
      .CFG_BITS(CFG_BITS)
   ) u_chain (
      .clk       (clk),
      .rst       (rst),
      .cfg_in    (cfg_in),
      .cfg_shift (cfg_shift),
      .cfg_commit(cfg_commit),
      .cfg_clear (cfg_clear),
      .cfg_out   (cfg_out),
      .cfg_done  (cfg_done),
      .cfg_err   (cfg_err),
      .cfg_full  (cfg_full),
      .active    (active)
   );

   assign din[DIR_N] = in_n;
   assign din[DIR_E] = in_e;
   assign din[DIR_S] = in_s;
   assign din[DIR_W] = in_w;

   always_comb begin
      sel_t sel;
      sel = SEL_OFF;
      for (int o = 0; o < 4; o++) begin
         route[o] = '0;
         for (int i = 0; i < WIDTH; i++) begin
            sel = active[(i*4+o)*2 +: 2];
            if (sel != SEL_OFF) begin
               route[o][i] = din[src_dir(dir_e'(2'(o)), sel)][i];
            end
         end
      end
   end

   if (REG_OUT != 0) begin : g_reg_out
      always_ff @(posedge clk) begin
         if (rst) begin
            dout <= '{default: '0};
         end else begin
            dout <= route;
         end
      end
   end else begin : g_comb_out
      assign dout = route;
   end

   assign out_n = dout[DIR_N];
   assign out_e = dout[DIR_E];
   assign out_s = dout[DIR_S];
   assign out_w = dout[DIR_W];

endmodule

// File: tb/tb_wilton_sb_cfg.sv
// Randomized self-checking bench: a combinational and a registered instance share
// stimulus and are compared every cycle against a behavioural model of the box.
module tb_wilton_sb_cfg;

   localparam int W  = 2;
   localparam int CB = W * 8;

   logic clk = 1'b0;
   logic rst;
   logic [W-1:0] in_n, in_e, in_s, in_w;
   logic cfg_in, cfg_shift, cfg_commit, cfg_clear;
   logic [W-1:0] c_n, c_e, c_s, c_w, r_n, r_e, r_s, r_w;
   logic c_cout, c_done, c_err, c_full, r_cout, r_done, r_err, r_full;

   logic [W-1:0] din [4];
   logic [W-1:0] c_out [4];
   logic [W-1:0] r_out [4];

   // Behavioural model
   logic [CB-1:0] m_shadow, m_active;
   int            m_count;
   logic          m_err, m_done;
   logic [W-1:0]  m_reg [4];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   wilton_sb_cfg #(.WIDTH(W), .REG_OUT(0)) u_comb (
      .clk(clk), .rst(rst),
      .in_n(in_n), .in_e(in_e), .in_s(in_s), .in_w(in_w),
      .out_n(c_n), .out_e(c_e), .out_s(c_s), .out_w(c_w),
      .cfg_in(cfg_in), .cfg_shift(cfg_shift), .cfg_commit(cfg_commit), .cfg_clear(cfg_clear),
      .cfg_out(c_cout), .cfg_done(c_done), .cfg_err(c_err), .cfg_full(c_full)
   );

   wilton_sb_cfg #(.WIDTH(W), .REG_OUT(1)) u_reg (
      .clk(clk), .rst(rst),
      .in_n(in_n), .in_e(in_e), .in_s(in_s), .in_w(in_w),
      .out_n(r_n), .out_e(r_e), .out_s(r_s), .out_w(r_w),
      .cfg_in(cfg_in), .cfg_shift(cfg_shift), .cfg_commit(cfg_commit), .cfg_clear(cfg_clear),
      .cfg_out(r_cout), .cfg_done(r_done), .cfg_err(r_err), .cfg_full(r_full)
   );

   assign din[0] = in_n;
   assign din[1] = in_e;
   assign din[2] = in_s;
   assign din[3] = in_w;
   assign c_out[0] = c_n;
   assign c_out[1] = c_e;
   assign c_out[2] = c_s;
   assign c_out[3] = c_w;
   assign r_out[0] = r_n;
   assign r_out[1] = r_e;
   assign r_out[2] = r_s;
   assign r_out[3] = r_w;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
      end
   endtask

   // Output side o takes side (o+sel+1) mod 4 for sel 0..2, zero for sel 3.
   function automatic logic [W-1:0] route_model(input logic [CB-1:0] act, input int o);
      logic [W-1:0] r;
      int sel;
      r = '0;
      for (int i = 0; i < W; i++) begin
         sel = int'(act[(i*4+o)*2 +: 2]);
         if (sel != 3) r[i] = din[(o + sel + 1) % 4][i];
      end
      return r;
   endfunction

   task automatic model_tick();
      if (rst) begin
         m_shadow = '0;
         m_active = '1;
         m_count  = 0;
         m_err    = 1'b0;
         m_done   = 1'b0;
         for (int o = 0; o < 4; o++) m_reg[o] = '0;
      end else begin
         for (int o = 0; o < 4; o++) m_reg[o] = route_model(m_active, o);
         m_done = 1'b0;
         if (cfg_clear) begin
            m_count = 0;
            m_err   = 1'b0;
         end else if (cfg_shift && cfg_commit) begin
            m_err = 1'b1;
         end else if (cfg_shift) begin
            m_shadow = {m_shadow[CB-2:0], cfg_in};
            if (m_count == CB) m_err = 1'b1;
            else m_count++;
         end else if (cfg_commit) begin
            if (m_count == CB) begin
               m_active = m_shadow;
               m_done   = 1'b1;
               m_count  = 0;
            end else begin
               m_err = 1'b1;
            end
         end
      end
   endtask

   task automatic compare_all();
      check("c_full", c_full, m_count == CB);
      check("r_full", r_full, m_count == CB);
      check("c_err", c_err, m_err);
      check("r_err", r_err, m_err);
      check("c_done", c_done, m_done);
      check("r_done", r_done, m_done);
      check("c_cfg_out", c_cout, m_shadow[CB-1]);
      check("r_cfg_out", r_cout, m_shadow[CB-1]);
      for (int o = 0; o < 4; o++) begin
         check($sformatf("c_out%0d", o), c_out[o], route_model(m_active, o));
         check($sformatf("r_out%0d", o), r_out[o], m_reg[o]);
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_tick();
      #1;
      compare_all();
   endtask

   task automatic rand_in();
      in_n = W'($urandom);
      in_e = W'($urandom);
      in_s = W'($urandom);
      in_w = W'($urandom);
   endtask

   task automatic drive(input logic sh, input logic cm, input logic cl, input logic b);
      cfg_shift  = sh;
      cfg_commit = cm;
      cfg_clear  = cl;
      cfg_in     = b;
   endtask

   // Shift the low n bits of w, most significant first.
   task automatic shift_bits(input logic [31:0] w, input int n);
      for (int k = 0; k < n; k++) begin
         rand_in();
         drive(1'b1, 1'b0, 1'b0, w[n-1-k]);
         step();
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic commit_once();
      drive(1'b0, 1'b1, 1'b0, 1'b0);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      rand_in();
      step();
      rand_in();
      step();
      check("rst_full", c_full, 1'b0);
      check("rst_out_s", c_s, '0);
      rst = 1'b0;

      // Track 0: E from W and W from E, both straight; everything else off.
      shift_bits(32'h0000_FF77, CB);
      commit_once();
      check("commit_done", c_done, 1'b1);
      step();
      check("done_pulse_end", c_done, 1'b0);
      in_w = 2'b01; in_e = 2'b00; in_n = 2'b11; in_s = 2'b11;
      step();
      check("route_e", c_e, 2'b01);
      in_e = 2'b01; in_w = 2'b00;
      step();
      check("route_w", c_w, 2'b01);
      check("route_e_off", c_e, 2'b00);

      // Premature commit then clear.
      shift_bits(32'h0000_0155, 10);
      commit_once();
      check("early_err", c_err, 1'b1);
      check("early_done", c_done, 1'b0);
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step();
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      check("clear_err", c_err, 1'b0);

      // Overflow: 17 shifts, commit still takes the last 16 bits.
      shift_bits(32'h0000_FF77, CB + 1);
      check("ovf_full", c_full, 1'b1);
      check("ovf_err", c_err, 1'b1);
      check("ovf_cfg_out", c_cout, 1'b1);
      commit_once();
      drive(1'b0, 1'b0, 1'b1, 1'b0);
      step();

      // Simultaneous shift+commit in FULL is rejected; track 1 N->S straight.
      shift_bits(32'h0000_DFFF, CB);
      drive(1'b1, 1'b1, 1'b0, 1'b0);
      step();
      check("both_err", c_err, 1'b1);
      check("both_full", c_full, 1'b1);
      commit_once();

      in_n = 2'b00;
      step();
      in_n = 2'b10;
      #1;
      check("reg_lag", r_s, 2'b00);
      step();
      check("reg_follow", r_s, 2'b10);
      in_n = 2'b00;
      step();
      check("reg_follow0", r_s, 2'b00);

      // Reset mid-load.
      shift_bits(32'h0000_0013, 5);
      rst = 1'b1;
      in_n = 2'b11; in_e = 2'b11; in_s = 2'b11; in_w = 2'b11;
      step();
      rst = 1'b0;
      step();
      check("midrst_s", c_s, 2'b00);
      check("midrst_reg_s", r_s, 2'b00);

      for (int t = 0; t < 3000; t++) begin
         int r;
         r = $urandom_range(99);
         rand_in();
         rst = (r == 0);
         cfg_in = 1'($urandom);
         cfg_shift  = (r >= 1 && r < 60) || (r == 70);
         cfg_commit = (r >= 60 && r <= 70);
         cfg_clear  = (r == 71 || r == 72);
         step();
      end
      rst = 1'b0;
      drive(1'b0, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/wilton_sb_cfg.md
Name: wilton_sb_cfg

Overview:
- Next-generation Wilton switch box. Each track is unidirectional per side, with WIDTH input lanes and WIDTH output lanes per direction.
- Every output lane has its own source select, so disjoint turns on one track can coexist (e.g. S->E together with N->W).
- Routing config is loaded serially into a shadow chain and applied atomically with a commit handshake, so the FPGA fabric can be reconfigured without glitching partial routes.

Parameters:
- WIDTH, 8, tracks per side.
- REG_OUT, 0, 0 = outputs combinational from inputs; 1 = outputs registered (1-cycle latency).
- CFG_BITS, WIDTH*8 (localparam), shadow/active config size: 4 output dirs x 2 bits per track.

Ports:
- clk  in  1  fabric config/route clock
- rst  in  1  synchronous active-high reset
- in_n, in_e, in_s, in_w  in  WIDTH  track inputs arriving from each side
- out_n, out_e, out_s, out_w  out  WIDTH  track outputs leaving each side
- cfg_in  in  1  serial config data
- cfg_shift  in  1  shift cfg_in into shadow this cycle
- cfg_commit  in  1  request shadow->active transfer
- cfg_clear  in  1  clear bit count and cfg_err; shadow contents kept
- cfg_out  out  1  shadow MSB (daisy-chain to next box)
- cfg_done  out  1  one-cycle pulse: commit accepted
- cfg_err  out  1  sticky protocol error
- cfg_full  out  1  exactly CFG_BITS bits shifted since last clear/commit

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Direction codes: N=0, E=1, S=2, W=3.
- Select per output (track i, dir o) is active[(i*4+o)*2 +: 2]:
  - 00 -> in[(o+1)%4][i]
  - 01 -> in[(o+2)%4][i] (straight)
  - 10 -> in[(o+3)%4][i]
  - 11 -> drive 0 (off)
- No tristates anywhere. No self-loop is encodable.
- REG_OUT=0: outputs follow inputs combinationally, using the current active config.
- REG_OUT=1: outputs are flops updated every cycle; 1-cycle latency.
- Shift: when cfg_shift=1, shadow <= {shadow[CFG_BITS-2:0], cfg_in} and count increments.
  - The first bit shifted lands at the MSB after CFG_BITS shifts.
  - cfg_out = shadow[CFG_BITS-1], registered by construction.
- FSM states: EMPTY (count=0), LOADING (0<count<CFG_BITS), FULL (count=CFG_BITS). cfg_full=1 only in FULL.
- Transitions:
  - EMPTY -shift-> LOADING.
  - LOADING -shift, count reaches CFG_BITS-> FULL.
  - FULL -shift-> FULL: shift still occurs, count saturates, cfg_err<=1 (overflow).
  - FULL -commit-> EMPTY: active<=shadow and cfg_done=1 on the next cycle. New routing is visible from the cycle after commit.
  - Commit in EMPTY or LOADING: cfg_err<=1, active unchanged, state unchanged.
- Simultaneous shift and commit in the same cycle: both ignored, cfg_err<=1.
- cfg_clear: count<=0, state<=EMPTY, cfg_err<=0. Overrides shift and commit in the same cycle.
- Reset:
  - active <= all ones, so every output is off and drives 0.
  - shadow <= 0, count <= 0, EMPTY.
  - cfg_done, cfg_err <= 0; out_* <= 0 (REG_OUT=1).
  - Reset mid-load discards the partial load; active config is all-off.
- Count width is $clog2(CFG_BITS+1).

Decomposition:
- Package wilton_pkg:
  - dir_e enum {DIR_N, DIR_E, DIR_S, DIR_W}
  - sel_t 2-bit with SEL_LEFT=00, SEL_STRAIGHT=01, SEL_RIGHT=10, SEL_OFF=11
  - function src_dir(o, sel)
  - cfg_state_e {CFG_EMPTY, CFG_LOADING, CFG_FULL}
- Sub-module wilton_cfg_chain: shift register, counter, FSM, commit/error logic, and the active register. Outputs active[CFG_BITS-1:0].
- Top instantiates the chain and generates the per-track, per-direction 4:1 muxes.

Test Plan:
- Reset -> cfg_full=0, cfg_err=0, all out_*=0 for any in_* pattern.
- WIDTH=2: shift 16 bits so track0 out_e sel=01 (from W) and track0 out_w sel=01 (from E), all others 11; commit.
  - Expected: cfg_done pulses one cycle after commit.
  - in_w=01, in_e=00 -> out_e=01. in_e=01, in_w=00 -> out_w=01. Both routes active together.
- Commit after only 10 shifts -> cfg_err=1, cfg_done=0, routing unchanged; then cfg_clear -> cfg_err=0, state EMPTY.
- Shift 17 bits -> cfg_full=1, cfg_err=1; cfg_out equals bit 1 shifted; commit still accepted with the last 16 bits.
- Assert cfg_shift and cfg_commit together in FULL -> cfg_err=1, active unchanged, count unchanged.
- REG_OUT=1, straight route N->S on track1: toggle in_n[1] -> out_s[1] follows exactly one clock later. Assert rst mid-load -> outputs 0, active all-off.
